instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage directly downstream of the PC counter. Accepts fetch
//  addresses, issues word reads to instruction memory over a req/gnt + rvalid
//  interface, and buffers {pc, instruction} pairs in a small FIFO feeding decode.
//  The redirect input (taken branch/jump) flushes buffered and in-flight fetches.
// PARAMETERS
//  OPD_WIDTH   32  instruction/data word width
//  PC_WIDTH    12  fetch address width (byte address)
//  FIFO_DEPTH  2   output buffer entries; power of 2, >= 2
// PORTS
//  clk          in   1                      clock, all state on rising edge
//  rst          in   1                      asynchronous, active-high reset
//  pc_in        in   PC_WIDTH               fetch address from PC counter
//  pc_valid     in   1                      pc_in valid
//  pc_ready     out  1                      stage accepts pc_in this cycle
//  redirect     in   1                      flush: taken branch/jump
//  imem_req     out  1                      read request to instruction memory
//  imem_addr    out  PC_WIDTH               read address, bits [1:0] forced 0
//  imem_gnt     in   1                      memory accepted request
//  imem_rvalid  in   1                      read data valid
//  imem_rdata   in   OPD_WIDTH              read data
//  instr_valid  out  1                      FIFO head valid to decode
//  instr_ready  in   1                      decode consumes head
//  instr        out  OPD_WIDTH              FIFO head instruction
//  instr_pc     out  PC_WIDTH               FIFO head fetch address
//  fifo_count   out  $clog2(FIFO_DEPTH)+1   entries held
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, fifo_count=0, instr_valid=0, instr=0,
//   instr_pc=0, imem_req=0, imem_addr=0, pc_ready=0 while rst high.
//  FSM (one outstanding request max):
//   IDLE : pc_ready = (fifo_count < FIFO_DEPTH). pc_valid&pc_ready -> latch
//          pc_in into imem_addr, -> REQ.
//   REQ  : imem_req=1, imem_addr stable until imem_gnt. gnt -> WAIT, or
//          DRAIN if a redirect occurred during REQ (sticky discard flag).
//   WAIT : imem_rvalid -> push {imem_addr, imem_rdata} into FIFO, -> IDLE.
//   DRAIN: imem_rvalid -> discard data, clear flag, -> IDLE.
//   pc_ready=0 in REQ/WAIT/DRAIN. imem_req never withdrawn before gnt.
//  Credit: pc accepted only if a FIFO slot is free, so a returning word
//   always has space; imem_rvalid is never back-pressured.
//  Latency: pc accepted at edge N -> imem_req high from N; gnt at edge N+1,
//   rvalid at edge N+2 -> instr_valid high after edge N+2 (min 3 cycles
//   pc_valid-to-instr_valid).
//  FIFO: instr/instr_pc show head while instr_valid=1; pop on
//   instr_valid&instr_ready; push and pop same cycle -> count unchanged,
//   order preserved. Pointers wrap modulo FIFO_DEPTH.
//  Redirect (any state): FIFO emptied at that edge (count=0, instr_valid=0
//   next cycle; a pop in the same cycle is void). In WAIT -> DRAIN; in REQ
//   -> set discard flag; rvalid in the same cycle as redirect is discarded.
//   Redirect in IDLE with pc_valid&pc_ready: new pc is accepted (it is the
//   redirect target) and fetched normally.
//  rst asserted mid-transaction: all state cleared immediately; memory
//   responses arriving after rst release while IDLE are ignored.
// TESTING
//  1 Reset: rst=1 mid-WAIT -> imem_req=0, instr_valid=0, fifo_count=0 at once.
//  2 Single fetch: pc_in=0x010, gnt next cycle, rvalid+rdata=0x00500093 ->
//    instr=0x00500093, instr_pc=0x010, 3 cycles after pc handshake.
//  3 Back-pressure: instr_ready=0, fetch 0x000,0x004 -> fifo_count=2,
//    pc_ready=0; pop one -> pc_ready=1, order 0x000 then 0x004.
//  4 Redirect in WAIT: fetch 0x020, redirect before rvalid -> data dropped,
//    FIFO empty; next pc 0x100 fetched and delivered with instr_pc=0x100.
//  5 Redirect in REQ with gnt delayed 4 cycles -> imem_req held, addr stable,
//    response discarded; simultaneous push+pop keeps count constant.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding word read per accepted PC, results buffered in a small FIFO to decode.
// Accept to instr_valid is 3 cycles minimum; a PC is taken only when a FIFO slot is free; redirect flushes.
module instr_fetch #(
  parameter int OPD_WIDTH  = 32,
  parameter int PC_WIDTH   = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PC_WIDTH-1:0]             pc_in,
  input  logic                            pc_valid,
  output logic                            pc_ready,
  input  logic                            redirect,
  output logic                            imem_req,
  output logic [PC_WIDTH-1:0]             imem_addr,
  input  logic                            imem_gnt,
  input  logic                            imem_rvalid,
  input  logic [OPD_WIDTH-1:0]            imem_rdata,
  output logic                            instr_valid,
  input  logic                            instr_ready,
  output logic [OPD_WIDTH-1:0]            instr,
  output logic [PC_WIDTH-1:0]             instr_pc,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]       DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] ADDR_MASK = ~PC_WIDTH'(3);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 discard_q, discard_d;
  logic [PC_WIDTH-1:0]  addr_q, addr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [OPD_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [OPD_WIDTH-1:0] data_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]  pcm_q  [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]  pcm_d  [FIFO_DEPTH];

  logic accept, push, pop;

  assign pc_ready    = !rst && (state_q == S_IDLE) && (count_q < DEPTH_C);
  assign accept      = pc_valid && pc_ready;
  assign instr_valid = (count_q != '0);
  // A response coinciding with a redirect belongs to the squashed path.
  assign push        = (state_q == S_WAIT) && imem_rvalid && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = addr_q;
  assign fifo_count  = count_q;
  assign instr       = instr_valid ? data_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pcm_q[rd_ptr_q]  : '0;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    addr_d    = addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = pc_in & ADDR_MASK;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d   = (discard_q || redirect) ? S_DRAIN : S_WAIT;
          discard_d = 1'b0;
        end else begin
          discard_d = discard_q || redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid)   state_d = S_IDLE;
        else if (redirect) state_d = S_DRAIN;
      end
      default: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    pcm_d    = pcm_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = imem_rdata;
        pcm_d[wr_ptr_q]  = addr_q;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      addr_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_q    <= '{default: '0};
      pcm_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      pcm_q     <= pcm_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked every cycle against a queue model.
module tb_instr_fetch;
  localparam int OW = 32;
  localparam int AW = 12;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_in = '0;
  logic          pc_valid = 1'b0;
  logic          pc_ready;
  logic          redirect = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [OW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [OW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [1:0]    fifo_count;

  always #5 clk = ~clk;

  instr_fetch #(.OPD_WIDTH(OW), .PC_WIDTH(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .redirect(redirect), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .fifo_count(fifo_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    if (a == 12'h010) return 32'h00500093;
    return {8'hA5, a, ~a};
  endfunction

  // Reference model: a queue of delivered words plus the single fetch in flight.
  typedef struct { logic [AW-1:0] pc; logic [OW-1:0] w; } ent_t;
  ent_t          mq[$];
  bit            m_out, m_gnt, m_dead;
  logic [AW-1:0] m_addr;

  // Memory responder knobs.
  int gnt_dly = 0, rsp_dly = 0, gcnt = 0, rcnt = 0;
  bit rnd_mode = 0, stray = 0;

  always @(negedge clk) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (m_out && !m_gnt) begin
      imem_gnt = rnd_mode ? ($urandom_range(0, 2) == 0) : (gcnt >= gnt_dly);
      gcnt++;
    end else gcnt = 0;
    if (m_out && m_gnt) begin
      if (rnd_mode ? ($urandom_range(0, 2) == 0) : (rcnt >= rsp_dly)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(m_addr);
      end
      rcnt++;
    end else rcnt = 0;
    if (!m_out && (stray || (rnd_mode && $urandom_range(0, 7) == 0))) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEADBEEF;
    end
  end

  always @(posedge clk) begin
    bit acc, gev, rev;
    if (rst) begin
      mq.delete();
      m_out = 0; m_gnt = 0; m_dead = 0;
    end else begin
      acc = pc_valid && !m_out && (mq.size() < D);
      gev = m_out && !m_gnt && imem_gnt;
      rev = m_out && m_gnt && imem_rvalid;
      if (redirect) begin
        mq.delete();
        if (m_out) m_dead = 1;
      end else if (mq.size() > 0 && instr_ready) begin
        void'(mq.pop_front());
      end
      if (rev) begin
        if (!m_dead && !redirect) mq.push_back('{pc: m_addr, w: imem_rdata});
        m_out = 0; m_gnt = 0; m_dead = 0;
      end
      if (gev) m_gnt = 1;
      if (acc) begin
        m_out = 1; m_gnt = 0; m_dead = 0;
        m_addr = pc_in & ~12'h003;
      end
    end
    #1;
    chk("pc_ready", pc_ready, !rst && !m_out && (mq.size() < D));
    chk("imem_req", imem_req, m_out && !m_gnt);
    if (m_out && !m_gnt) chk("imem_addr", imem_addr, m_addr);
    chk("fifo_count", fifo_count, mq.size());
    chk("instr_valid", instr_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("instr", instr, mq[0].w);
      chk("instr_pc", instr_pc, mq[0].pc);
    end else if (rst) begin
      chk("instr_rst", instr, 0);
      chk("instr_pc_rst", instr_pc, 0);
      chk("imem_addr_rst", imem_addr, 0);
    end
  end

  task automatic do_fetch(input logic [AW-1:0] a);
    int t;
    t = 0;
    @(negedge clk);
    while (!pc_ready && t < 100) begin @(negedge clk); t++; end
    chk("pc_ready_wait", pc_ready, 1);
    pc_in = a;
    pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int n);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (int'(fifo_count) != n && t < 100) begin @(posedge clk); #1; t++; end
    chk("wait_cnt", 32'(fifo_count), n);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", fifo_count, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_instr", instr, 0);
    @(negedge clk); rst = 1'b0;

    // Single fetch with minimum latency.
    @(negedge clk); pc_in = 12'h010; pc_valid = 1'b1;
    @(posedge clk); #1;
    chk("t2_req", imem_req, 1);
    chk("t2_addr", imem_addr, 12'h010);
    chk("t2_pc_ready", pc_ready, 0);
    @(negedge clk); pc_valid = 1'b0;
    @(posedge clk); #1;
    chk("t2_not_yet", instr_valid, 0);
    @(posedge clk); #1;
    chk("t2_valid", instr_valid, 1);
    chk("t2_instr", instr, 32'h00500093);
    chk("t2_pc", instr_pc, 12'h010);
    chk("t2_count", fifo_count, 1);

    // Reset asserted while waiting for read data.
    rsp_dly = 5;
    do_fetch(12'h030);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t1_req", imem_req, 0);
    chk("t1_valid", instr_valid, 0);
    chk("t1_count", fifo_count, 0);
    @(negedge clk); rst = 1'b0; stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    @(posedge clk); #1;
    chk("t1_stray", fifo_count, 0);
    rsp_dly = 0;

    // Back-pressure fills the FIFO and blocks the PC.
    instr_ready = 1'b0;
    do_fetch(12'h000);
    do_fetch(12'h004);
    wait_cnt(2);
    chk("t3_pc_ready", pc_ready, 0);
    chk("t3_head", instr_pc, 12'h000);
    @(negedge clk); instr_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_pc_ready1", pc_ready, 1);
    chk("t3_count1", fifo_count, 1);
    chk("t3_head2", instr_pc, 12'h004);
    chk("t3_word2", instr, 32'hA5004FFB);
    @(negedge clk); instr_ready = 1'b0;

    // Redirect during WAIT drops the response and flushes the FIFO.
    rsp_dly = 3;
    do_fetch(12'h020);
    @(negedge clk); redirect = 1'b1;
    @(posedge clk); #1;
    chk("t4_flush", fifo_count, 0);
    chk("t4_valid", instr_valid, 0);
    @(negedge clk); redirect = 1'b0;
    do_fetch(12'h100);
    wait_cnt(1);
    chk("t4_pc", instr_pc, 12'h100);
    chk("t4_word", instr, 32'hA5100EFF);
    @(negedge clk); instr_ready = 1'b1;
    @(negedge clk); instr_ready = 1'b0;

    // Redirect during a long REQ; request held stable, response discarded.
    gnt_dly = 4; rsp_dly = 0;
    do_fetch(12'h040);
    redirect = 1'b1;
    @(posedge clk); #1;
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 12'h040);
    @(negedge clk); redirect = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_req_hold", imem_req, 1);
      chk("t5_addr_hold", imem_addr, 12'h040);
    end
    wait_cnt(0);
    gnt_dly = 0;
    do_fetch(12'h080);
    wait_cnt(1);
    do_fetch(12'h084);
    @(negedge clk); instr_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_pushpop_cnt", fifo_count, 1);
    chk("t5_pushpop_pc", instr_pc, 12'h084);
    @(negedge clk); instr_ready = 1'b0;

    // Random traffic against the model.
    rnd_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      pc_valid    = $urandom_range(0, 1);
      pc_in       = AW'($urandom);
      redirect    = ($urandom_range(0, 19) == 0);
      instr_ready = $urandom_range(0, 1);
      rst         = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0; pc_valid = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
